// File: rtl/mlp_pkg.sv
// Shared constants and encodings for the MLP datapath: pu geometry, buffer widths,
// feeder FSM states and layer codes.
package mlp_pkg;

    localparam int unsigned N_MAC   = 64;
    localparam int unsigned XW      = 25;
    localparam int unsigned WSLOT   = 20;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned MAC_LAT = 2;
    localparam int unsigned CNT_W   = $clog2(N_MAC);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StFetch = 3'd2,
        StFlush = 3'd3,
        StDrain = 3'd4,
        StDone  = 3'd5
    } feed_state_e;

    typedef enum logic [2:0] {
        LayerNone    = 3'd0,
        LayerHidden1 = 3'd1,
        LayerHidden2 = 3'd2,
        LayerHidden3 = 3'd3,
        LayerHidden4 = 3'd4,
        LayerOutput  = 3'd5
    } layer_e;

endpackage

// File: rtl/feed_addr_gen.sv
// Base + offset address counter. Load captures the base and zeroes the offset; o_last flags
// the final offset of an i_len-long burst.
module feed_addr_gen
    import mlp_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_off;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_base <= '0;
            r_off  <= '0;
        end else if (i_load) begin
            r_base <= i_base;
            r_off  <= '0;
        end else if (i_inc) begin
            r_off <= r_off + 1'b1;
        end
    end

    // Dropping the offset MSB gives the mod 2^ADDR_W wrap.
    assign o_addr = r_base + r_off[ADDR_W-1:0];
    assign o_last = (r_off == i_len - 1'b1);

endmodule

// File: rtl/pu_feeder.sv
// Input-side sequencer for the 64-lane pu: clear, stream len activation/weight pairs,
// wait for the MAC pipeline, then hold pu_signal for N_MAC cycles while results drain.
module pu_feeder
    import mlp_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_start,
    input  logic [ADDR_W:0]        i_len,
    input  logic [2:0]             i_layer_state,
    input  logic [ADDR_W-1:0]      i_x_base,
    input  logic [ADDR_W-1:0]      i_w_base,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_x_rd_en,
    output logic [ADDR_W-1:0]      o_x_rd_addr,
    input  logic [XW-1:0]          i_x_rd_data,
    output logic                   o_w_rd_en,
    output logic [ADDR_W-1:0]      o_w_rd_addr,
    input  logic [N_MAC*WSLOT-1:0] i_w_rd_data,
    output logic                   o_pu_enable,
    output logic                   o_pu_clear,
    output logic [XW-1:0]          o_pu_data1,
    output logic [N_MAC*WSLOT-1:0] o_pu_data2,
    output logic                   o_pu_signal,
    output logic [2:0]             o_pu_state
);

    feed_state_e       r_state, w_state_next;
    logic [ADDR_W:0]   r_len;
    logic [2:0]        r_layer;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pu_enable;
    logic              w_accept, w_fetch, w_x_last, w_w_last;
    logic [ADDR_W-1:0] w_x_addr, w_w_addr;

    assign w_accept = (r_state == StIdle) && i_start;
    assign w_fetch  = (r_state == StFetch);

    feed_addr_gen u_x_addr (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_load (w_accept),
        .i_inc  (w_fetch),
        .i_base (i_x_base),
        .i_len  (r_len),
        .o_addr (w_x_addr),
        .o_last (w_x_last)
    );

    feed_addr_gen u_w_addr (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_load (w_accept),
        .i_inc  (w_fetch),
        .i_base (i_w_base),
        .i_len  (r_len),
        .o_addr (w_w_addr),
        .o_last (w_w_last)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_cnt restarts on every state change; FLUSH and DRAIN time themselves with it.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_len       <= '0;
            r_layer     <= '0;
            r_cnt       <= '0;
            r_pu_enable <= 1'b0;
        end else begin
            r_pu_enable <= w_fetch;
            r_cnt       <= (w_state_next == r_state) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_len   <= i_len;
                r_layer <= i_layer_state;
            end else if (r_state == StDone) begin
                r_layer <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_next = StClear;
            StClear: w_state_next = (r_len == '0) ? StFlush : StFetch;
            StFetch: if (w_x_last && w_w_last) w_state_next = StFlush;
            StFlush: if (r_cnt == CNT_W'(MAC_LAT)) w_state_next = StDrain;
            StDrain: if (r_cnt == CNT_W'(N_MAC - 1)) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_pu_clear  = 1'b0;
        o_pu_signal = 1'b0;
        o_x_rd_en   = 1'b0;
        o_w_rd_en   = 1'b0;
        o_x_rd_addr = '0;
        o_w_rd_addr = '0;
        unique case (r_state)
            StClear: begin
                o_busy     = 1'b1;
                o_pu_clear = 1'b1;
            end
            StFetch: begin
                o_busy      = 1'b1;
                o_x_rd_en   = 1'b1;
                o_w_rd_en   = 1'b1;
                o_x_rd_addr = w_x_addr;
                o_w_rd_addr = w_w_addr;
            end
            StFlush: o_busy = 1'b1;
            StDrain: begin
                o_busy      = 1'b1;
                o_pu_signal = 1'b1;
            end
            StDone:  o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_pu_enable = r_pu_enable;
    assign o_pu_data1  = i_x_rd_data;
    assign o_pu_data2  = i_w_rd_data;
    assign o_pu_state  = r_layer;

endmodule

// File: tb/tb_pu_feeder.sv
// Bench for pu_feeder: per-cycle timeline model, buffer models, and a behavioural pu whose
// drained results are compared with dot products computed straight from the buffers.
module tb_pu_feeder;

    localparam int NMAC = 64;
    localparam int MACL = 2;
    localparam int AW   = 10;
    localparam int XWB  = 25;
    localparam int WSL  = 20;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rstn, start;
    logic [AW:0] len;
    logic [2:0] layer;
    logic [AW-1:0] xb, wb;
    logic busy, done, x_rd_en, w_rd_en, pu_enable, pu_clear, pu_signal;
    logic [AW-1:0] x_rd_addr, w_rd_addr;
    logic [XWB-1:0] x_rd_data = '0, pu_data1;
    logic [NMAC*WSL-1:0] w_rd_data = '0, pu_data2;
    logic [2:0] pu_state;

    logic [XWB-1:0] x_mem [DEPTH];
    logic [NMAC*WSL-1:0] w_mem [DEPTH];
    longint acc [NMAC];
    longint got [NMAC];
    int d_idx = 0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pu_feeder dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_start       (start),
        .i_len         (len),
        .i_layer_state (layer),
        .i_x_base      (xb),
        .i_w_base      (wb),
        .o_busy        (busy),
        .o_done        (done),
        .o_x_rd_en     (x_rd_en),
        .o_x_rd_addr   (x_rd_addr),
        .i_x_rd_data   (x_rd_data),
        .o_w_rd_en     (w_rd_en),
        .o_w_rd_addr   (w_rd_addr),
        .i_w_rd_data   (w_rd_data),
        .o_pu_enable   (pu_enable),
        .o_pu_clear    (pu_clear),
        .o_pu_data1    (pu_data1),
        .o_pu_data2    (pu_data2),
        .o_pu_signal   (pu_signal),
        .o_pu_state    (pu_state)
    );

    function automatic longint sx(input logic [XWB-1:0] v);
        logic signed [XWB-1:0] s;
        s = v;
        return longint'(s);
    endfunction

    function automatic longint sw(input logic [17:0] v);
        logic signed [17:0] s;
        s = v;
        return longint'(s);
    endfunction

    // Synchronous-read buffers.
    always @(posedge clk) begin
        if (x_rd_en) x_rd_data <= x_mem[x_rd_addr];
        if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
    end

    // Behavioural pu: accumulate on enable, serialise one lane per pu_signal cycle.
    always @(posedge clk) begin
        for (int i = 0; i < NMAC; i++) begin
            if (pu_clear) acc[i] <= 0;
            else if (pu_enable) acc[i] <= acc[i] + sx(pu_data1) * sw(pu_data2[i*WSL +: 18]);
        end
        if (pu_signal) begin
            if (d_idx < NMAC) got[d_idx] <= acc[d_idx];
            d_idx <= d_idx + 1;
        end else begin
            d_idx <= 0;
        end
    end

    task automatic check(input string name, input int c, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0d: got %0h, expected %0h", name, c, act, exp);
        end
    endtask

    function automatic logic [29:0] act_vec();
        return {busy, done, x_rd_en, x_rd_addr, w_rd_en, w_rd_addr, pu_enable, pu_clear,
                pu_signal, pu_state};
    endfunction

    // Expected control outputs at cycle c after a start sampled at cycle 0.
    function automatic logic [29:0] exp_vec(input int c, input int tl, input int txb,
                                            input int twb, input int tlay);
        int sig_lo, done_c;
        logic rd;
        logic [AW-1:0] xa, wa;
        sig_lo = tl + 3 + MACL;
        done_c = sig_lo + NMAC;
        rd = (c >= 2) && (c <= tl + 1);
        xa = rd ? AW'((txb + c - 2) % DEPTH) : '0;
        wa = rd ? AW'((twb + c - 2) % DEPTH) : '0;
        return {(c >= 1) && (c < done_c), c == done_c, rd, xa, rd, wa,
                (c >= 3) && (c <= tl + 2), c == 1,
                (c >= sig_lo) && (c < done_c),
                ((c >= 1) && (c <= done_c)) ? 3'(tlay) : 3'd0};
    endfunction

    // mode 0: start pulse only; 1: start held through DONE; 2: extra start pulse in DRAIN.
    task automatic run_tile(input string tag, input int tl, input int txb, input int twb,
                            input int tlay, input int mode, output int sig_first,
                            output int done_c, output int x_first, output int x_last,
                            output int n_dist);
        int last_c;
        bit seen [DEPTH];
        longint r;
        last_c = tl + 3 + MACL + NMAC;
        sig_first = -1;
        done_c = -1;
        x_first = -1;
        x_last = -1;
        n_dist = 0;
        @(posedge clk); #1;
        start = 1'b1;
        len = 11'(tl);
        xb = AW'(txb);
        wb = AW'(twb);
        layer = 3'(tlay);
        @(negedge clk);
        check({tag, " ctl"}, 0, 64'(act_vec()), 64'(exp_vec(0, tl, txb, twb, tlay)));
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk); #1;
            start = (mode == 1) || (mode == 2 && c == tl + 20);
            len = 11'($urandom);
            xb = AW'($urandom);
            wb = AW'($urandom);
            layer = 3'($urandom);
            @(negedge clk);
            check({tag, " ctl"}, c, 64'(act_vec()), 64'(exp_vec(c, tl, txb, twb, tlay)));
            if (pu_signal && sig_first < 0) sig_first = c;
            if (done) done_c = c;
            if (x_rd_en) begin
                if (x_first < 0) x_first = int'(x_rd_addr);
                x_last = int'(x_rd_addr);
                if (!seen[x_rd_addr]) begin
                    seen[x_rd_addr] = 1'b1;
                    n_dist++;
                end
            end
        end
        for (int i = 0; i < NMAC; i++) begin
            r = 0;
            for (int k = 0; k < tl; k++)
                r += sx(x_mem[(txb + k) % DEPTH]) * sw(w_mem[(twb + k) % DEPTH][i*WSL +: 18]);
            check({tag, " out2"}, i, 64'(got[i]), 64'(r));
        end
    endtask

    typedef struct {
        int tl, txb, twb, tlay, mode;
        int e_sig, e_done, e_xf, e_xl;
    } tvec_t;

    initial begin
        tvec_t tab [6];
        int sf, dc, xf, xl, nd, gap;

        tab[0] = '{3, 10, 40, 1, 0, 8, 72, 10, 12};
        tab[1] = '{0, 5, 6, 2, 0, 5, 69, -1, -1};
        tab[2] = '{4, 1022, 7, 3, 2, 9, 73, 1022, 1};
        tab[3] = '{1, 1023, 1023, 5, 1, 6, 70, 1023, 1023};
        tab[4] = '{1024, 0, 512, 4, 0, 1029, 1093, 0, 1023};
        tab[5] = '{16, 300, 900, 5, 0, 21, 85, 300, 315};

        for (int a = 0; a < DEPTH; a++) begin
            x_mem[a] = XWB'($urandom);
            for (int j = 0; j < NMAC; j++) w_mem[a][j*WSL +: WSL] = WSL'($urandom);
        end

        rstn = 1'b0;
        start = 1'b0;
        len = '0;
        xb = '0;
        wb = '0;
        layer = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset state", 0, 64'(act_vec()), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int t = 0; t < 6; t++) begin
            run_tile("tab", tab[t].tl, tab[t].txb, tab[t].twb, tab[t].tlay, tab[t].mode,
                     sf, dc, xf, xl, nd);
            check("tab sig_first", t, 64'(sf), 64'(tab[t].e_sig));
            check("tab done_cyc", t, 64'(dc), 64'(tab[t].e_done));
            check("tab x_first", t, 64'(xf), 64'(tab[t].e_xf));
            check("tab x_last", t, 64'(xl), 64'(tab[t].e_xl));
            check("tab distinct", t, 64'(nd), 64'(tab[t].tl));
        end

        // Reset while fetching: tile dies silently, then a fresh tile runs normally.
        @(posedge clk); #1;
        start = 1'b1;
        len = 11'd10;
        xb = 10'd100;
        wb = 10'd200;
        layer = 3'd2;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 5) rstn = 1'b0;
        end
        @(negedge clk);
        check("rst pre fetch", 5, 64'(x_rd_en), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst mid fetch", 6, 64'(act_vec()), 64'd0);
        for (int c = 7; c < 90; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst quiet", c, 64'(act_vec()), 64'd0);
        end
        run_tile("post rst", 7, 50, 60, 3, 0, sf, dc, xf, xl, nd);
        check("post rst done", 0, 64'(dc), 64'd76);

        for (int t = 0; t < 20; t++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                check("idle gap", g, 64'(act_vec()), 64'd0);
            end
            run_tile("rnd", $urandom_range(0, 40), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, DEPTH - 1), $urandom_range(1, 5),
                     $urandom_range(0, 2), sf, dc, xf, xl, nd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
